// File: rtl/squarewave_pkg.sv
// Shared defaults and helpers for the square-wave generator.
// HALF_PERIOD is derived here so parent designs can compute it the same way.
package squarewave_pkg;

  localparam int unsigned DefaultClkFreqHz  = 50_000_000;
  localparam int unsigned DefaultOutFreqHz  = 1000;
  localparam int unsigned DefaultSyncStages = 2;

  // Cycles per output half-period; a zero output frequency yields 0 so elaboration can reject it.
  function automatic int unsigned calc_half_period(input int unsigned clk_freq_hz,
                                                   input int unsigned out_freq_hz);
    if (out_freq_hz == 0) return 0;
    return clk_freq_hz / (2 * out_freq_hz);
  endfunction

  function automatic int unsigned calc_cnt_width(input int unsigned half_period);
    return (half_period > 1) ? $clog2(half_period) : 1;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level signal.
// The last stage is the synchronized output.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  if (STAGES < 2) begin : g_bad_stages
    $error("sync_ff: STAGES must be at least 2");
  end

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/squarewave_generator.sv
// Enable-gated square-wave generator: a half-period counter drives a toggle flop.
// Disabling clears the phase so every re-enable starts with Pulse low.
module squarewave_generator
  import squarewave_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = DefaultClkFreqHz,
  parameter int unsigned OUT_FREQ_HZ = DefaultOutFreqHz,
  parameter int unsigned SYNC_STAGES = DefaultSyncStages
) (
  input  logic sysclk,
  input  logic rst_n,
  input  logic Enable_SW_3,
  output logic Pulse
);

  localparam int unsigned HALF_PERIOD = calc_half_period(CLK_FREQ_HZ, OUT_FREQ_HZ);
  localparam int unsigned CntW        = calc_cnt_width(HALF_PERIOD);
  localparam logic [CntW-1:0] CntMax  = CntW'(HALF_PERIOD - 1);

  if (HALF_PERIOD < 1) begin : g_bad_half_period
    $error("squarewave_generator: HALF_PERIOD must be at least 1");
  end

  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("squarewave_generator: SYNC_STAGES must be at least 2");
  end

  logic            enable_s;
  logic [CntW-1:0] half_cnt;
  logic            pulse_q;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync_ff (
    .clk  (sysclk),
    .rst_n(rst_n),
    .d    (Enable_SW_3),
    .q    (enable_s)
  );

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      half_cnt <= '0;
      pulse_q  <= 1'b0;
    end else if (!enable_s) begin
      half_cnt <= '0;
      pulse_q  <= 1'b0;
    end else if (half_cnt == CntMax) begin
      half_cnt <= '0;
      pulse_q  <= ~pulse_q;
    end else begin
      half_cnt <= half_cnt + 1'b1;
    end
  end

  assign Pulse = pulse_q;

endmodule

// File: tb/tb_squarewave_generator.sv
// Directed bench: HALF_PERIOD=4, HALF_PERIOD=1 and default-parameter instances
// share one clock and reset; each has its own enable.
module tb_squarewave_generator;

  logic sysclk;
  logic rst_n;
  logic en_a, en_b, en_c;
  logic pulse_a, pulse_b, pulse_c;

  int tests;
  int fails;

  squarewave_generator #(
    .CLK_FREQ_HZ(8),
    .OUT_FREQ_HZ(1),
    .SYNC_STAGES(2)
  ) u_a (
    .sysclk     (sysclk),
    .rst_n      (rst_n),
    .Enable_SW_3(en_a),
    .Pulse      (pulse_a)
  );

  squarewave_generator #(
    .CLK_FREQ_HZ(2),
    .OUT_FREQ_HZ(1),
    .SYNC_STAGES(2)
  ) u_b (
    .sysclk     (sysclk),
    .rst_n      (rst_n),
    .Enable_SW_3(en_b),
    .Pulse      (pulse_b)
  );

  squarewave_generator u_c (
    .sysclk     (sysclk),
    .rst_n      (rst_n),
    .Enable_SW_3(en_c),
    .Pulse      (pulse_c)
  );

  initial sysclk = 1'b0;
  always #10 sysclk = ~sysclk;

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    en_a  = 1'b1;
    en_b  = 1'b0;
    en_c  = 1'b0;

    // Reset held with enable high: outputs stay clear, including between edges.
    #5;
    check("rst_pulse_pre_edge", 32'(pulse_a), 0);
    check("rst_cnt_pre_edge", 32'(u_a.half_cnt), 0);
    tick();
    tick();
    #4;
    check("rst_pulse_mid", 32'(pulse_a), 0);
    check("rst_cnt_mid", 32'(u_a.half_cnt), 0);
    tick();

    // Release; next edge is E0 (first high sample). Rise E0+5, fall E0+9, rise E0+13.
    rst_n = 1'b1;
    tick();
    check("e0_pulse", 32'(pulse_a), 0);
    for (int k = 1; k <= 14; k++) begin
      tick();
      check($sformatf("run_e0p%0d", k), 32'(pulse_a),
            (k < 5) ? 0 : ((((k - 5) / 4) % 2 == 0) ? 1 : 0));
    end

    // Drop enable while Pulse is high; next edge F0 samples low.
    en_a = 1'b0;
    tick();
    tick();
    check("drop_f0p1_still_high", 32'(pulse_a), 1);
    tick();
    check("drop_f0p2_low", 32'(pulse_a), 0);
    check("drop_f0p2_cnt", 32'(u_a.half_cnt), 0);
    repeat (4) tick();
    check("drop_stays_low", 32'(pulse_a), 0);

    // Re-enable; next edge G0. First rise at G0+5.
    en_a = 1'b1;
    tick();
    repeat (3) tick();
    tick();
    check("reen_g0p4", 32'(pulse_a), 0);
    tick();
    check("reen_g0p5", 32'(pulse_a), 1);

    // Unsampled low glitch between edges must not disturb the phase.
    en_a = 1'b0;
    #3;
    en_a = 1'b1;
    repeat (3) tick();
    check("glitch_g0p8", 32'(pulse_a), 1);
    tick();
    check("glitch_g0p9", 32'(pulse_a), 0);

    // Advance to G0+14 (Pulse high, mid-period), then a 3 ns reset between edges.
    repeat (5) tick();
    check("pre_rst_high", 32'(pulse_a), 1);
    #4;
    rst_n = 1'b0;
    #1;
    check("async_rst_pulse", 32'(pulse_a), 0);
    check("async_rst_cnt", 32'(u_a.half_cnt), 0);
    #2;
    rst_n = 1'b1;
    tick();
    repeat (4) tick();
    check("post_rst_h0p4", 32'(pulse_a), 0);
    tick();
    check("post_rst_h0p5", 32'(pulse_a), 1);

    // HALF_PERIOD=1: toggle every enabled edge, first rise at B0+2.
    en_b = 1'b1;
    tick();
    check("hp1_b0", 32'(pulse_b), 0);
    tick();
    check("hp1_b0p1", 32'(pulse_b), 0);
    tick();
    check("hp1_b0p2", 32'(pulse_b), 1);
    tick();
    check("hp1_b0p3", 32'(pulse_b), 0);
    tick();
    check("hp1_b0p4", 32'(pulse_b), 1);

    // Defaults: HALF_PERIOD=25000, rise at C0+25001, fall at C0+50001.
    en_c = 1'b1;
    tick();
    repeat (25000) tick();
    check("def_c0p25000", 32'(pulse_c), 0);
    tick();
    check("def_c0p25001", 32'(pulse_c), 1);
    repeat (24999) tick();
    check("def_c0p50000", 32'(pulse_c), 1);
    tick();
    check("def_c0p50001", 32'(pulse_c), 0);

    // 2 us disable then re-enable must restart phase from zero.
    repeat (12000) tick();
    en_c = 1'b0;
    repeat (100) tick();
    check("def_disabled", 32'(pulse_c), 0);
    check("def_disabled_cnt", 32'(u_c.half_cnt), 0);
    en_c = 1'b1;
    tick();
    repeat (25000) tick();
    check("def_r0p25000", 32'(pulse_c), 0);
    tick();
    check("def_r0p25001", 32'(pulse_c), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
